// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op/cond encodings, FSM states, flag bit positions
// and the condition evaluator used on registered flags.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLL = 3'd4,
        OP_SRL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        CS_EQ     = 3'd0,
        CS_NE     = 3'd1,
        CS_LT     = 3'd2,
        CS_GE     = 3'd3,
        CS_LTU    = 3'd4,
        CS_GEU    = 3'd5,
        CS_NEG    = 3'd6,
        CS_ALWAYS = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic eval_cond(input cond_e sel, input logic [3:0] f);
        logic r;
        r = 1'b0;
        case (sel)
            CS_EQ:     r = f[FLAG_Z];
            CS_NE:     r = !f[FLAG_Z];
            CS_LT:     r = f[FLAG_N] ^ f[FLAG_V];
            CS_GE:     r = !(f[FLAG_N] ^ f[FLAG_V]);
            CS_LTU:    r = !f[FLAG_C];
            CS_GEU:    r = f[FLAG_C];
            CS_NEG:    r = f[FLAG_N];
            CS_ALWAYS: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, LSB of b first.
// prod presents the accumulator value after the current step so the caller can latch it on done.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               busy_q, busy_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] acc_step;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        addend   = acc_q[0] ? mcand_q : '0;
        hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_step = {hi_sum, acc_q[WIDTH-1:1]};
        done     = busy_q && (count_q == LAST);
        prod     = acc_step;
    end

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        if (start) begin
            busy_d  = 1'b1;
            count_d = '0;
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
        end else if (busy_q) begin
            acc_d   = acc_step;
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake, registered result/flags/cond and an
// iterative multiplier; single-cycle ops go straight from accept to DONE.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [2:0]       cond_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             cond
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             cond_q, cond_d;
    cond_e            cond_sel_q, cond_sel_d;

    op_e              op_in;
    cond_e            cond_in;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [3:0]         mul_flags;

    assign op_in   = op_e'(op);
    assign cond_in = cond_e'(cond_sel);
    assign amt     = b[SHW-1:0];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Single-cycle datapath works on the request ports so the result lands on the accept edge.
    always_comb begin
        b_eff   = (op_in == OP_SUB) ? ~b : b;
        cin     = (op_in == OP_SUB);
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_in)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLL:  alu_res = a << amt;
            OP_SRL:  alu_res = a >> amt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> amt);
            default: alu_res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;

        mul_flags         = '0;
        mul_flags[FLAG_N] = mul_prod[WIDTH-1];
        mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
        mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        cond_d     = cond_q;
        cond_sel_d = cond_sel_q;
        mul_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cond_sel_d = cond_in;
                    if (op_in == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        cond_d   = eval_cond(cond_in, alu_flags);
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    result_d = mul_prod[WIDTH-1:0];
                    flags_d  = mul_flags;
                    cond_d   = eval_cond(cond_sel_q, mul_flags);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            cond_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cond_q   <= cond_d;
        end
    end

    always_ff @(posedge clk) begin
        cond_sel_q <= cond_sel_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign cond      = cond_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=32 instance for most scenarios plus a WIDTH=8
// instance for the narrow multiply latency case.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cond;
    logic [31:0] a, b, result;
    logic [2:0]  op, cond_sel;
    logic [3:0]  flags;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cond8;
    logic [7:0]  a8, b8, result8;
    logic [2:0]  op8, cond_sel8;
    logic [3:0]  flags8;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cond_sel(cond_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .cond(cond)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .cond_sel(cond_sel8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .flags(flags8), .cond(cond8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] av, input logic [31:0] bv,
                       input logic [2:0] o, input logic [2:0] c);
        a = av; b = bv; op = o; cond_sel = c; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h want=0", result); end
        total++; if (flags !== 4'h0) begin bad++; $display("FAIL rst_flags got=%b want=0000", flags); end
        total++; if (cond !== 1'b0) begin bad++; $display("FAIL rst_cond got=%b want=0", cond); end
        total++; if ({in_ready8, out_valid8, result8} !== {1'b1, 1'b0, 8'h00}) begin
            bad++; $display("FAIL rst_w8 got=%b%b/%h want=10/00", in_ready8, out_valid8, result8);
        end
    endtask

    task automatic test_add_overflow();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_pre_valid got=%b want=0", out_valid); end
        req(32'h7FFF_FFFF, 32'h1, OP_ADD, CS_NE);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_latency got=%b want=1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_in_ready got=%b want=0", in_ready); end
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h want=80000000", result); end
        total++; if (flags !== 4'b1001) begin bad++; $display("FAIL add_flags got=%b want=1001", flags); end
        total++; if (cond !== 1'b1) begin bad++; $display("FAIL add_cond got=%b want=1", cond); end
        drain();
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL add_release got=%b%b want=01", out_valid, in_ready); end
    endtask

    task automatic test_sub();
        req(32'd5, 32'd5, OP_SUB, CS_EQ);
        total++; if (result !== 32'h0) begin bad++; $display("FAIL sub_eq_result got=%h want=0", result); end
        total++; if (flags !== 4'b0110) begin bad++; $display("FAIL sub_eq_flags got=%b want=0110", flags); end
        total++; if (cond !== 1'b1) begin bad++; $display("FAIL sub_eq_cond got=%b want=1", cond); end
        drain();
        req(32'd3, 32'd7, OP_SUB, CS_LTU);
        total++; if (result !== 32'hFFFF_FFFC) begin bad++; $display("FAIL sub_ltu_result got=%h want=fffffffc", result); end
        total++; if (flags !== 4'b1000) begin bad++; $display("FAIL sub_ltu_flags got=%b want=1000", flags); end
        total++; if (cond !== 1'b1) begin bad++; $display("FAIL sub_ltu_cond got=%b want=1", cond); end
        drain();
        req(32'h8000_0000, 32'd1, OP_SUB, CS_LT);
        total++; if ({result, flags, cond} !== {32'h7FFF_FFFF, 4'b0011, 1'b1}) begin
            bad++; $display("FAIL sub_ovf got=%h/%b/%b want=7fffffff/0011/1", result, flags, cond);
        end
        drain();
    endtask

    task automatic test_logic_shift();
        req(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, CS_EQ);
        total++; if ({result, flags, cond} !== {32'h00F0_00F0, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL and got=%h/%b/%b want=00f000f0/0000/0", result, flags, cond);
        end
        drain();
        req(32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_OR, CS_NEG);
        total++; if ({result, flags, cond} !== {32'hFFF0_FFF0, 4'b1000, 1'b1}) begin
            bad++; $display("FAIL or got=%h/%b/%b want=fff0fff0/1000/1", result, flags, cond);
        end
        drain();
        req(32'h8000_0000, 32'h0000_0021, OP_SRA, CS_NEG);
        total++; if ({result, flags, cond} !== {32'hC000_0000, 4'b1000, 1'b1}) begin
            bad++; $display("FAIL sra got=%h/%b/%b want=c0000000/1000/1", result, flags, cond);
        end
        drain();
        req(32'h8000_0000, 32'd4, OP_SRL, CS_EQ);
        total++; if (result !== 32'h0800_0000) begin bad++; $display("FAIL srl got=%h want=08000000", result); end
        drain();
        req(32'h1234_5678, 32'h0000_0020, OP_SLL, CS_ALWAYS);
        total++; if ({result, flags, cond} !== {32'h1234_5678, 4'b0000, 1'b1}) begin
            bad++; $display("FAIL sll_amt0 got=%h/%b/%b want=12345678/0000/1", result, flags, cond);
        end
        drain();
        req(32'h0000_0003, 32'd30, OP_SLL, CS_EQ);
        total++; if (result !== 32'hC000_0000) begin bad++; $display("FAIL sll got=%h want=c0000000", result); end
        drain();
    endtask

    task automatic test_mul();
        int n;
        int early;
        req(32'h0001_0000, 32'h0001_0000, OP_MUL, CS_EQ);
        early = 0;
        for (int i = 0; i < 32; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
            step();
        end
        total++; if (early != 0) begin bad++; $display("FAIL mul_busy_window got=%0d want=0", early); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_latency got=%b want=1", out_valid); end
        total++; if ({result, flags, cond} !== {32'h0, 4'b0110, 1'b1}) begin
            bad++; $display("FAIL mul_wrap got=%h/%b/%b want=00000000/0110/1", result, flags, cond);
        end
        drain();
        req(32'h0000_1234, 32'h0000_0010, OP_MUL, CS_NE);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
        total++; if (n != 32) begin bad++; $display("FAIL mul_small_cycles got=%0d want=32", n); end
        total++; if ({result, flags, cond} !== {32'h0001_2340, 4'b0000, 1'b1}) begin
            bad++; $display("FAIL mul_small got=%h/%b/%b want=00012340/0000/1", result, flags, cond);
        end
        drain();
        req(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, CS_GEU);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
        total++; if ({result, flags, cond} !== {32'h0000_0001, 4'b0010, 1'b1}) begin
            bad++; $display("FAIL mul_max got=%h/%b/%b want=00000001/0010/1", result, flags, cond);
        end
        drain();
    endtask

    task automatic test_backpressure();
        req(32'd10, 32'd20, OP_ADD, CS_GE);
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1; op = OP_SUB;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if ({out_valid, in_ready, result, flags, cond} !== {1'b1, 1'b0, 32'd30, 4'b0000, 1'b1}) begin
                bad++; $display("FAIL hold_%0d got=%b%b/%h/%b/%b want=10/0000001e/0000/1",
                                i, out_valid, in_ready, result, flags, cond);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        total++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'd30}) begin
            bad++; $display("FAIL release got=%b%b/%h want=01/0000001e", out_valid, in_ready, result);
        end
        a = 32'd1; b = 32'd1; op = OP_ADD; cond_sel = CS_EQ; in_valid = 1'b1;
        step();
        total++; if ({out_valid, result} !== {1'b1, 32'd2}) begin
            bad++; $display("FAIL b2b_first got=%b/%h want=1/00000002", out_valid, result);
        end
        a = 32'd2; b = 32'd2;
        step();
        total++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'd2}) begin
            bad++; $display("FAIL b2b_gap got=%b%b/%h want=01/00000002", out_valid, in_ready, result);
        end
        step();
        total++; if ({out_valid, result} !== {1'b1, 32'd4}) begin
            bad++; $display("FAIL b2b_second got=%b/%h want=1/00000004", out_valid, result);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_rst_mid_mul();
        int seen;
        req(32'd3, 32'd5, OP_MUL, CS_ALWAYS);
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({in_ready, out_valid, result, flags, cond} !== {1'b1, 1'b0, 32'h0, 4'h0, 1'b0}) begin
            bad++; $display("FAIL rst_mid got=%b%b/%h/%b/%b want=10/00000000/0000/0",
                            in_ready, out_valid, result, flags, cond);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_abort got=%0d want=0", seen); end
        req(32'd2, 32'd3, OP_ADD, CS_EQ);
        total++; if ({out_valid, result, flags, cond} !== {1'b1, 32'd5, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL rst_then_add got=%b/%h/%b/%b want=1/00000005/0000/0",
                            out_valid, result, flags, cond);
        end
        drain();
    endtask

    task automatic test_mul_w8();
        int early;
        a8 = 8'h10; b8 = 8'h10; op8 = OP_MUL; cond_sel8 = CS_NE; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        early = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid8 !== 1'b0 || in_ready8 !== 1'b0) early++;
            step();
        end
        total++; if (early != 0) begin bad++; $display("FAIL w8_busy_window got=%0d want=0", early); end
        total++; if ({out_valid8, result8, flags8, cond8} !== {1'b1, 8'h00, 4'b0110, 1'b0}) begin
            bad++; $display("FAIL w8_mul got=%b/%h/%b/%b want=1/00/0110/0", out_valid8, result8, flags8, cond8);
        end
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        total++; if ({out_valid8, in_ready8} !== 2'b01) begin
            bad++; $display("FAIL w8_release got=%b%b want=01", out_valid8, in_ready8);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; cond_sel = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; cond_sel8 = '0;
        #1;
        test_reset();
        test_add_overflow();
        test_sub();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_rst_mid_mul();
        test_mul_w8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
